// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch port and the
// data port. At most one access is in flight; data normally wins, but a
// fetch that has been passed over STARVE_MAX times in a row gets priority.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_DM = 2'd2;

  // Counter value in the final busy cycle, and the starvation ceiling.
  localparam logic [3:0] LAST_CNT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]    state_r;
  logic [3:0]    cnt_r;
  logic [3:0]    starve_r;
  logic          flushed_r;
  logic          en_r;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic [DW-1:0] if_rdata_r;
  logic [DW-1:0] dm_rdata_r;
  logic          if_done_r;
  logic          dm_done_r;

  logic          if_pend_s;
  logic          dm_pend_s;
  logic          grant_if_s;
  logic          grant_dm_s;
  logic          last_s;
  logic          if_drop_s;
  logic [3:0]    starve_inc_s;

  // Arbitration: a request is invisible in its own done cycle, and a fetch
  // is also invisible while a flush is being signalled.
  always_comb begin
    if_pend_s  = if_req & ~if_done_r & ~if_flush;
    dm_pend_s  = dm_req & ~dm_done_r;
    grant_if_s = 1'b0;
    grant_dm_s = 1'b0;
    if (state_r == IDLE) begin
      grant_if_s = if_pend_s & (~dm_pend_s | (starve_r == STARVE_LIM));
      grant_dm_s = dm_pend_s & ~grant_if_s;
    end else begin
      grant_if_s = 1'b0;
      grant_dm_s = 1'b0;
    end
  end

  // Busy-window end detection, flush suppression and saturating starve step.
  always_comb begin
    last_s    = (cnt_r == LAST_CNT);
    if_drop_s = flushed_r | if_flush;
    if (starve_r == STARVE_LIM) begin
      starve_inc_s = starve_r;
    end else begin
      starve_inc_s = starve_r + 4'd1;
    end
  end

  // Main controller: grant, run the MEM_LAT-cycle access window, complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      starve_r   <= 4'd0;
      flushed_r  <= 1'b0;
      en_r       <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= {AW{1'b0}};
      wdata_r    <= {DW{1'b0}};
      if_rdata_r <= {DW{1'b0}};
      dm_rdata_r <= {DW{1'b0}};
      if_done_r  <= 1'b0;
      dm_done_r  <= 1'b0;
    end else begin
      // Done flags are single-cycle pulses unless set again below.
      if_done_r <= 1'b0;
      dm_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_if_s) begin
            state_r   <= BUSY_IF;
            cnt_r     <= 4'd0;
            starve_r  <= 4'd0;
            flushed_r <= 1'b0;
            en_r      <= 1'b1;
            we_r      <= 1'b0;
            addr_r    <= if_addr;
            wdata_r   <= {DW{1'b0}};
          end else if (grant_dm_s) begin
            state_r   <= BUSY_DM;
            cnt_r     <= 4'd0;
            starve_r  <= if_pend_s ? starve_inc_s : starve_r;
            flushed_r <= 1'b0;
            en_r      <= 1'b1;
            we_r      <= dm_we;
            addr_r    <= dm_addr;
            wdata_r   <= dm_wdata;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (last_s) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            flushed_r <= 1'b0;
            en_r      <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= {AW{1'b0}};
            wdata_r   <= {DW{1'b0}};
            if (state_r == BUSY_IF) begin
              // A fetch flushed at any point in its window completes silently.
              if (!if_drop_s) begin
                if_done_r  <= 1'b1;
                if_rdata_r <= mem_rdata;
              end
            end else begin
              dm_done_r <= 1'b1;
              if (!we_r) begin
                dm_rdata_r <= mem_rdata;
              end
            end
          end else begin
            cnt_r     <= cnt_r + 4'd1;
            flushed_r <= flushed_r | ((state_r == BUSY_IF) & if_flush);
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= 4'd0;
          flushed_r <= 1'b0;
          en_r      <= 1'b0;
          we_r      <= 1'b0;
          addr_r    <= {AW{1'b0}};
          wdata_r   <= {DW{1'b0}};
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_r;
  assign dm_rdata  = dm_rdata_r;
  assign if_done   = if_done_r;
  assign dm_done   = dm_done_r;
  assign mem_en    = en_r;
  assign mem_we    = we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign if_stall  = if_req & ~if_done_r & ~if_flush;
  assign dm_stall  = dm_req & ~dm_done_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model that tracks the
// in-flight access by its grant edge number.
module tb_mem_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, if_stall, dm_done, dm_stall, mem_en, mem_we;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          edge_n;
  bit          m_busy, m_own_if, m_we, m_flushed;
  int          m_start, m_starve;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  bit          m_if_done, m_dm_done;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_own_if = 0; m_we = 0; m_flushed = 0;
    m_start = 0; m_starve = 0;
    m_addr = 32'h0; m_wdata = 32'h0;
    m_if_rdata = 32'h0; m_dm_rdata = 32'h0;
    m_if_done = 0; m_dm_done = 0;
  endtask

  task automatic check_outputs();
    chk("mem_en", {31'h0, mem_en}, {31'h0, m_busy});
    chk("mem_we", {31'h0, mem_we}, {31'h0, m_busy & m_we});
    chk("mem_addr", mem_addr, m_busy ? m_addr : 32'h0);
    if (!(m_busy && m_own_if)) chk("mem_wdata", mem_wdata, m_busy ? m_wdata : 32'h0);
    chk("if_done", {31'h0, if_done}, {31'h0, m_if_done});
    chk("dm_done", {31'h0, dm_done}, {31'h0, m_dm_done});
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("dm_rdata", dm_rdata, m_dm_rdata);
    chk("if_stall", {31'h0, if_stall}, {31'h0, if_req & ~m_if_done & ~if_flush});
    chk("dm_stall", {31'h0, dm_stall}, {31'h0, dm_req & ~m_dm_done});
  endtask

  // One clock cycle: check the current cycle at the falling edge, predict the
  // effect of the coming rising edge, then return 1 time unit after it.
  task automatic step();
    bit n_if_done, n_dm_done, ip, dp;
    @(negedge clk);
    check_outputs();
    n_if_done = 0; n_dm_done = 0;
    if (m_busy) begin
      if (m_own_if && if_flush) m_flushed = 1;
      if (edge_n + 1 == m_start + MEM_LAT) begin
        m_busy = 0;
        if (m_own_if) begin
          if (!m_flushed) begin n_if_done = 1; m_if_rdata = mem_rdata; end
        end else begin
          n_dm_done = 1;
          if (!m_we) m_dm_rdata = mem_rdata;
        end
      end
    end else begin
      ip = if_req && !m_if_done && !if_flush;
      dp = dm_req && !m_dm_done;
      if (ip && (!dp || m_starve == STARVE_MAX)) begin
        m_busy = 1; m_own_if = 1; m_start = edge_n + 1; m_flushed = 0;
        m_addr = if_addr; m_we = 0; m_wdata = 32'h0; m_starve = 0;
      end else if (dp) begin
        m_busy = 1; m_own_if = 0; m_start = edge_n + 1; m_flushed = 0;
        m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
        if (ip && m_starve < STARVE_MAX) m_starve = m_starve + 1;
      end
    end
    @(posedge clk);
    edge_n++;
    m_if_done = n_if_done;
    m_dm_done = n_dm_done;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_flush = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;
    model_reset();
    edge_n = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_done", {31'h0, dm_done}, 32'h0);
    rst = 1'b0;

    // Lone fetch, addr 0x10, memory returns 0xDEADBEEF
    if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    step();                                  // grant edge
    chk("f_en_c1", {31'h0, mem_en}, 32'h1);
    chk("f_addr_c1", mem_addr, 32'h10);
    step();
    chk("f_en_c2", {31'h0, mem_en}, 32'h1);
    step();                                  // completion edge
    chk("f_done_c3", {31'h0, if_done}, 32'h1);
    chk("f_rdata_c3", if_rdata, 32'hDEADBEEF);
    chk("f_en_c3", {31'h0, mem_en}, 32'h0);
    if_req = 1'b0;
    step();

    // Data write, addr 0x40 data 0x1234
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1234; mem_rdata = 32'h5555;
    step();
    chk("w_we_c1", {31'h0, mem_we}, 32'h1);
    chk("w_wdata_c1", mem_wdata, 32'h1234);
    chk("w_addr_c1", mem_addr, 32'h40);
    dm_addr = 32'h99; dm_wdata = 32'h77;     // changes mid-access must not leak
    step();
    chk("w_wdata_c2", mem_wdata, 32'h1234);
    step();
    chk("w_done", {31'h0, dm_done}, 32'h1);
    chk("w_rdata_kept", dm_rdata, 32'h0);
    dm_req = 1'b0; dm_we = 1'b0;
    step();

    // Fetch flushed in its first busy cycle
    if_req = 1'b1; if_addr = 32'h80; mem_rdata = 32'hCAFE0000;
    step();
    if_flush = 1'b1;
    step();
    if_flush = 1'b0; if_req = 1'b0;
    chk("fl_en_c2", {31'h0, mem_en}, 32'h1);
    step();
    chk("fl_no_done", {31'h0, if_done}, 32'h0);
    chk("fl_rdata_kept", if_rdata, 32'hDEADBEEF);
    chk("fl_idle", {31'h0, mem_en}, 32'h0);
    step();

    // Reset in the middle of a data read, request held across reset
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h60; mem_rdata = 32'h0BAD0BAD;
    step();
    #2 rst = 1'b1;
    #1;
    chk("ra_en", {31'h0, mem_en}, 32'h0);
    chk("ra_addr", mem_addr, 32'h0);
    chk("ra_if_rdata", if_rdata, 32'h0);
    chk("ra_dm_done", {31'h0, dm_done}, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("ra_regrant_en", {31'h0, mem_en}, 32'h1);
    chk("ra_regrant_addr", mem_addr, 32'h60);
    step();
    step();
    chk("ra_done", {31'h0, dm_done}, 32'h1);
    chk("ra_rdata", dm_rdata, 32'h0BAD0BAD);
    dm_req = 1'b0;
    step();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if_req    = ($urandom_range(0, 9) < 7);
      dm_req    = ($urandom_range(0, 9) < 7);
      if_flush  = ($urandom_range(0, 9) < 2);
      dm_we     = $urandom_range(0, 1) == 1;
      if_addr   = $urandom;
      dm_addr   = $urandom;
      dm_wdata  = $urandom;
      mem_rdata = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
